// File: rtl/sw_mode_ctrl_pkg.sv
// Shared types and constants for the stopwatch mode sequencer.
package sw_mode_ctrl_pkg;

    localparam int SEC_H_W      = 3;
    localparam int DIG_W        = 4;
    localparam int DISP_W       = SEC_H_W + 3 * DIG_W;
    localparam int DB_TICKS_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STOP = 3'd2,
        ST_LAP  = 3'd3,
        ST_DONE = 3'd4
    } sw_state_e;

    // STOP deliberately shares the IDLE pattern; it is only visible through pause.
    function automatic logic [2:0] state_led_of(input sw_state_e s);
        case (s)
            ST_RUN:  return 3'b001;
            ST_LAP:  return 3'b011;
            ST_DONE: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sw_btn_debounce.sv
// Button conditioner: 2-FF sync, stable-level debouncer, rising-edge press pulse.
// Latency: raw edge to o_press is 2 + DB_TICKS cycles; no backpressure.
module sw_btn_debounce #(
    parameter int DB_TICKS = 2
) (
    input  logic clk_100hz,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            // Any sample matching the accepted level restarts the stability run.
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_TICKS - 1)) begin
                r_lvl   <= r_s2;
                r_cnt   <= '0;
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/sw_mode_ctrl.sv
// Stopwatch mode sequencer: buttons to sw_en/pause/clear, lap capture, display mux.
// Latency: press pulse to outputs is 1 cycle, all outputs registered; no backpressure.
module sw_mode_ctrl
    import sw_mode_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF,
    parameter int LAP_W    = 4
) (
    input  logic               clk_100hz,
    input  logic               rst_n,
    input  logic               btn_ss,
    input  logic               btn_lr,
    input  logic               time_out,
    input  logic [SEC_H_W-1:0] live_sec_h,
    input  logic [DIG_W-1:0]   live_sec_l,
    input  logic [DIG_W-1:0]   live_msec_h,
    input  logic [DIG_W-1:0]   live_msec_l,
    output logic               sw_en,
    output logic               pause,
    output logic               clear,
    output logic [SEC_H_W-1:0] disp_sec_h,
    output logic [DIG_W-1:0]   disp_sec_l,
    output logic [DIG_W-1:0]   disp_msec_h,
    output logic [DIG_W-1:0]   disp_msec_l,
    output logic [LAP_W-1:0]   lap_cnt,
    output logic [2:0]         state_led
);

    logic              w_press_ss;
    logic              w_press_lr;
    sw_state_e         r_state;
    sw_state_e         w_nxt;
    logic              w_clear_nxt;
    logic              w_lap_take;
    logic [DISP_W-1:0] w_live;
    logic [DISP_W-1:0] r_latch;
    logic [DISP_W-1:0] r_disp;
    logic [LAP_W-1:0]  r_lap_cnt;
    logic              r_sw_en;
    logic              r_pause;
    logic              r_clear;
    logic [2:0]        r_led;

    sw_btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_ss (
        .clk_100hz (clk_100hz),
        .rst_n     (rst_n),
        .i_btn     (btn_ss),
        .o_press   (w_press_ss)
    );

    sw_btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_lr (
        .clk_100hz (clk_100hz),
        .rst_n     (rst_n),
        .i_btn     (btn_lr),
        .o_press   (w_press_lr)
    );

    assign w_live = {live_sec_h, live_sec_l, live_msec_h, live_msec_l};

    // Event priority within a state: time_out, then Start/Stop, then Lap/Reset.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_press_ss) w_nxt = ST_RUN;
            ST_RUN: begin
                if (time_out)        w_nxt = ST_DONE;
                else if (w_press_ss) w_nxt = ST_STOP;
                else if (w_press_lr) w_nxt = ST_LAP;
            end
            ST_LAP: begin
                if (time_out)        w_nxt = ST_DONE;
                else if (w_press_ss) w_nxt = ST_STOP;
                else if (w_press_lr) w_nxt = ST_RUN;
            end
            ST_STOP: begin
                if (w_press_ss)      w_nxt = ST_RUN;
                else if (w_press_lr) w_nxt = ST_IDLE;
            end
            ST_DONE: if (w_press_lr) w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
        w_clear_nxt = ((r_state == ST_STOP) || (r_state == ST_DONE)) && (w_nxt == ST_IDLE);
        w_lap_take  = (r_state == ST_RUN) && (w_nxt == ST_LAP);
    end

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sw_en   <= 1'b0;
            r_pause   <= 1'b0;
            r_clear   <= 1'b0;
            r_led     <= 3'b000;
            r_latch   <= '0;
            r_disp    <= '0;
            r_lap_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            r_sw_en <= (w_nxt != ST_IDLE);
            r_pause <= (w_nxt == ST_STOP) || (w_nxt == ST_DONE);
            r_clear <= w_clear_nxt;
            r_led   <= state_led_of(w_nxt);
            if (w_lap_take) r_latch <= w_live;
            // On the lap-entry cycle the latch is still being written, so show live directly.
            if (w_nxt == ST_LAP) r_disp <= w_lap_take ? w_live : r_latch;
            else                 r_disp <= w_live;
            if (w_clear_nxt)
                r_lap_cnt <= '0;
            else if (w_lap_take && (r_lap_cnt != {LAP_W{1'b1}}))
                r_lap_cnt <= r_lap_cnt + LAP_W'(1);
        end
    end

    assign sw_en     = r_sw_en;
    assign pause     = r_pause;
    assign clear     = r_clear;
    assign state_led = r_led;
    assign lap_cnt   = r_lap_cnt;
    assign {disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l} = r_disp;

endmodule

// File: tb/tb_sw_mode_ctrl.sv
// Randomized and directed bench for sw_mode_ctrl against a behavioural stopwatch model.
module tb_sw_mode_ctrl;

    localparam int DB = 2;
    localparam int LW = 4;

    logic          clk_100hz = 1'b0;
    logic          rst_n     = 1'b0;
    logic          btn_ss    = 1'b0;
    logic          btn_lr    = 1'b0;
    logic          time_out  = 1'b0;
    logic [2:0]    live_sec_h  = '0;
    logic [3:0]    live_sec_l  = '0;
    logic [3:0]    live_msec_h = '0;
    logic [3:0]    live_msec_l = '0;
    logic          sw_en, pause, clear;
    logic [2:0]    disp_sec_h;
    logic [3:0]    disp_sec_l, disp_msec_h, disp_msec_l;
    logic [LW-1:0] lap_cnt;
    logic [2:0]    state_led;

    sw_mode_ctrl #(.DB_TICKS(DB), .LAP_W(LW)) dut (
        .clk_100hz   (clk_100hz),
        .rst_n       (rst_n),
        .btn_ss      (btn_ss),
        .btn_lr      (btn_lr),
        .time_out    (time_out),
        .live_sec_h  (live_sec_h),
        .live_sec_l  (live_sec_l),
        .live_msec_h (live_msec_h),
        .live_msec_l (live_msec_l),
        .sw_en       (sw_en),
        .pause       (pause),
        .clear       (clear),
        .disp_sec_h  (disp_sec_h),
        .disp_sec_l  (disp_sec_l),
        .disp_msec_h (disp_msec_h),
        .disp_msec_l (disp_msec_l),
        .lap_cnt     (lap_cnt),
        .state_led   (state_led)
    );

    always #5 clk_100hz = ~clk_100hz;

    int errors = 0;
    int checks = 0;

    // Behavioural model: stopwatch modes plus "level accepted after DB equal samples".
    typedef enum int {M_IDLE, M_RUN, M_STOP, M_LAP, M_DONE} mst_t;
    mst_t        mst;
    bit          m_prs_ss, m_prs_lr, m_lvl_ss, m_lvl_lr;
    bit          q_ss[$];
    bit          q_lr[$];
    int          m_lap;
    logic [14:0] m_latch;
    logic [24:0] m_out;
    int          dev_cnt = 0;
    logic [24:0] dev_got, dev_exp;
    int          clr_cnt = 0;
    int          live_cs = 0;

    function automatic logic [24:0] got();
        return {sw_en, pause, clear, disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l,
                lap_cnt, state_led};
    endfunction

    function automatic logic [14:0] live_now();
        return {live_sec_h, live_sec_l, live_msec_h, live_msec_l};
    endfunction

    function automatic logic [14:0] cs_digits(input int cs);
        return {3'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
    endfunction

    task automatic set_live(input int cs);
        live_cs = cs;
        {live_sec_h, live_sec_l, live_msec_h, live_msec_l} = cs_digits(cs);
    endtask

    // Raw level seen by the debouncer j samples back (two synchroniser stages of delay).
    function automatic bit hist(input bit q[$], input int j);
        int idx;
        idx = q.size() - 3 - j;
        return (idx >= 0) ? q[idx] : 1'b0;
    endfunction

    function automatic bit deb_flip(input bit q[$], input bit lvl);
        for (int j = 0; j < DB; j++)
            if (hist(q, j) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mst = M_IDLE;
        m_prs_ss = 0; m_prs_lr = 0; m_lvl_ss = 0; m_lvl_lr = 0;
        q_ss.delete(); q_lr.delete();
        m_lap = 0; m_latch = '0; m_out = '0;
    endtask

    task automatic model_step();
        mst_t        nxt;
        bit          clr;
        logic [2:0]  led;
        logic [14:0] live;
        live = live_now();
        nxt  = mst;
        case (mst)
            M_IDLE: if (m_prs_ss) nxt = M_RUN;
            M_RUN:  if (time_out) nxt = M_DONE; else if (m_prs_ss) nxt = M_STOP;
                    else if (m_prs_lr) nxt = M_LAP;
            M_LAP:  if (time_out) nxt = M_DONE; else if (m_prs_ss) nxt = M_STOP;
                    else if (m_prs_lr) nxt = M_RUN;
            M_STOP: if (m_prs_ss) nxt = M_RUN; else if (m_prs_lr) nxt = M_IDLE;
            M_DONE: if (m_prs_lr) nxt = M_IDLE;
            default: nxt = M_IDLE;
        endcase
        clr = ((mst == M_STOP) || (mst == M_DONE)) && (nxt == M_IDLE);
        if (mst == M_RUN && nxt == M_LAP) begin
            m_latch = live;
            if (m_lap < 2**LW - 1) m_lap++;
        end
        if (clr) m_lap = 0;
        case (nxt)
            M_RUN:   led = 3'b001;
            M_LAP:   led = 3'b011;
            M_DONE:  led = 3'b100;
            default: led = 3'b000;
        endcase
        m_out = {nxt != M_IDLE, (nxt == M_STOP) || (nxt == M_DONE), clr,
                 (nxt == M_LAP) ? m_latch : live, LW'(m_lap), led};
        mst = nxt;
        q_ss.push_back(btn_ss);
        q_lr.push_back(btn_lr);
        if (q_ss.size() > 16) void'(q_ss.pop_front());
        if (q_lr.size() > 16) void'(q_lr.pop_front());
        m_prs_ss = 0;
        if (deb_flip(q_ss, m_lvl_ss)) begin m_lvl_ss = !m_lvl_ss; m_prs_ss = m_lvl_ss; end
        m_prs_lr = 0;
        if (deb_flip(q_lr, m_lvl_lr)) begin m_lvl_lr = !m_lvl_lr; m_prs_lr = m_lvl_lr; end
    endtask

    task automatic cyc();
        @(posedge clk_100hz);
        if (rst_n) model_step(); else model_reset();
        #1;
        if (got() !== m_out) begin
            if (dev_cnt == 0) begin dev_got = got(); dev_exp = m_out; end
            dev_cnt++;
        end
        if (clear === 1'b1) clr_cnt++;
    endtask

    task automatic press(input bit lr, input int hold, input int rel);
        for (int i = 0; i < hold + rel; i++) begin
            if (lr) btn_lr = (i < hold); else btn_ss = (i < hold);
            cyc();
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk_100hz);
        #1;
        checks++;
        if (got() !== 25'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", got()); end
        rst_n = 1'b1;
        set_live(0);
        cyc();
        checks++;
        if ({sw_en, clear, state_led} !== 5'b0) begin
            errors++; $display("FAIL reset_release: got %b want 00000", {sw_en, clear, state_led});
        end
    endtask

    task automatic test_start();
        clr_cnt = 0; dev_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            btn_ss = (i < 5);
            cyc();
            if (i == 3) begin
                checks++;
                if (sw_en !== 1'b0) begin errors++; $display("FAIL start_early: sw_en got %b want 0", sw_en); end
            end
            if (i == 4) begin
                checks++;
                if ({sw_en, pause, state_led} !== 5'b10001) begin
                    errors++; $display("FAIL start_latency: got %b want 10001", {sw_en, pause, state_led});
                end
            end
        end
        checks++;
        if (clr_cnt !== 0) begin errors++; $display("FAIL start_no_clear: clear cycles %0d want 0", clr_cnt); end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL start_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_lap();
        dev_cnt = 0;
        set_live(1234);
        for (int i = 0; i < 12; i++) begin
            btn_lr = (i < 3);
            if (i >= 6) set_live(live_cs + 1);
            cyc();
        end
        checks++;
        if ({disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l} !== 15'h1234) begin
            errors++; $display("FAIL lap_freeze: disp %h want 1234", {disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l});
        end
        checks++;
        if ({lap_cnt, state_led} !== {4'd1, 3'b011}) begin
            errors++; $display("FAIL lap_state: lap_cnt %0d led %b want 1 011", lap_cnt, state_led);
        end
        for (int i = 0; i < 10; i++) begin
            btn_lr = (i < 3);
            set_live(live_cs + 1);
            cyc();
        end
        checks++;
        if ({disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l, state_led} !== {cs_digits(live_cs), 3'b001}) begin
            errors++; $display("FAIL lap_release: disp %h led %b want %h 001",
                {disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l}, state_led, cs_digits(live_cs));
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL lap_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_bounce();
        dev_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            btn_ss = (i < 4) ? ((i % 2) == 0) : 1'b0;
            cyc();
        end
        checks++;
        if ({pause, state_led} !== 4'b0001) begin
            errors++; $display("FAIL bounce_ignored: pause %b led %b want 0 001", pause, state_led);
        end
        press(1'b0, 3, 5);
        checks++;
        if ({sw_en, pause, state_led} !== 5'b11000) begin
            errors++; $display("FAIL bounce_hold: got %b want 11000", {sw_en, pause, state_led});
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL bounce_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_stop_clear();
        dev_cnt = 0; clr_cnt = 0;
        press(1'b1, 3, 4);
        checks++;
        if (clr_cnt !== 1) begin errors++; $display("FAIL stop_clear_pulse: clear cycles %0d want 1", clr_cnt); end
        checks++;
        if ({sw_en, pause, lap_cnt} !== 6'b0) begin
            errors++; $display("FAIL stop_clear_state: sw_en %b pause %b lap_cnt %0d want 0 0 0", sw_en, pause, lap_cnt);
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL stop_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_done();
        dev_cnt = 0;
        press(1'b0, 3, 4);
        set_live(5999);
        for (int i = 0; i < 8; i++) begin
            btn_ss   = (i < 3);
            time_out = (i == 4);
            cyc();
            if (i == 4) begin
                checks++;
                if ({sw_en, pause, state_led} !== 5'b11100) begin
                    errors++; $display("FAIL done_priority: got %b want 11100", {sw_en, pause, state_led});
                end
            end
        end
        press(1'b0, 3, 4);
        checks++;
        if ({state_led, disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l} !== {3'b100, 15'h5999}) begin
            errors++; $display("FAIL done_ss_ignored: led %b disp %h want 100 5999",
                state_led, {disp_sec_h, disp_sec_l, disp_msec_h, disp_msec_l});
        end
        clr_cnt = 0;
        press(1'b1, 3, 4);
        checks++;
        if ({clr_cnt == 1, sw_en, state_led} !== 5'b10000) begin
            errors++; $display("FAIL done_clear: clear cycles %0d sw_en %b led %b want 1 0 000", clr_cnt, sw_en, state_led);
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL done_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_lap_sat();
        dev_cnt = 0;
        press(1'b0, 3, 4);
        for (int k = 0; k < 17; k++) begin
            set_live(100 + k);
            press(1'b1, 3, 4);
            press(1'b1, 3, 4);
        end
        checks++;
        if ({lap_cnt, state_led} !== {4'd15, 3'b001}) begin
            errors++; $display("FAIL lap_saturate: lap_cnt %0d led %b want 15 001", lap_cnt, state_led);
        end
        press(1'b1, 3, 4);
        checks++;
        if ({lap_cnt, state_led} !== {4'd15, 3'b011}) begin
            errors++; $display("FAIL lap_no_wrap: lap_cnt %0d led %b want 15 011", lap_cnt, state_led);
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL lapsat_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_reset_mid();
        dev_cnt = 0; clr_cnt = 0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got() !== 25'd0) begin errors++; $display("FAIL reset_async: got %h want 0", got()); end
        cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        checks++;
        if ({clr_cnt == 0, sw_en, state_led} !== 5'b10000) begin
            errors++; $display("FAIL reset_no_clear: clear cycles %0d sw_en %b led %b want 0 0 000", clr_cnt, sw_en, state_led);
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL resetmid_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    task automatic test_random();
        dev_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 3) == 0) btn_lr = ~btn_lr;
            time_out = ($urandom_range(0, 59) == 0);
            set_live(int'($urandom_range(0, 5999)));
            cyc();
        end
        checks++;
        if (dev_cnt !== 0) begin errors++; $display("FAIL random_model: %0d deviations, got %h want %h", dev_cnt, dev_got, dev_exp); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_bounce();
        test_stop_clear();
        test_done();
        test_lap_sat();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
